// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Latency: one cycle from ID/EX inputs to the *_mem_o outputs; pc_sel_o/pc_target_o are combinational.
// Backpressure: none; the register loads every edge and stalls are handled upstream by bubbles/flush.
//
// Ports:
//   clk_i, rst_ni                   clock (rising edge), async active-low reset
//   *_ex_i                          decoded instruction, operands and controls from ID/EX
//   flush_i                         load a bubble into EX/MEM and suppress any redirect
//   wb_data_i, rsW_wb_i, RegWEn_wb_i writeback result used as the second forwarding source
//   *_mem_o                         registered EX/MEM contents driving the memory stage
//   pc_sel_o, pc_target_o           fetch redirect request and target
module ex_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter bit          FWD_EN   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_ex_i,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] rs1_ex_i,
    input  logic [31:0] rs2_ex_i,
    input  logic [4:0]  rs1A_ex_i,
    input  logic [4:0]  rs2A_ex_i,
    input  logic [31:0] imm_ex_i,
    input  logic [31:0] inst_ex_i,
    input  logic [3:0]  ALUSel_ex_i,
    input  logic        ASel_ex_i,
    input  logic        BSel_ex_i,
    input  logic        BrEn_ex_i,
    input  logic        Jump_ex_i,
    input  logic        MemRW_ex_i,
    input  logic [1:0]  WBSel_ex_i,
    input  logic        RegWEn_ex_i,
    input  logic [4:0]  rsW_ex_i,
    input  logic        flush_i,
    input  logic [31:0] wb_data_i,
    input  logic [4:0]  rsW_wb_i,
    input  logic        RegWEn_wb_i,
    output logic [31:0] alu_mem_o,
    output logic [31:0] rs2_mem_o,
    output logic [31:0] pc4_mem_o,
    output logic [31:0] inst_mem_o,
    output logic        MemRW_mem_o,
    output logic        RegWEn_mem_o,
    output logic [1:0]  WBSel_mem_o,
    output logic [4:0]  rsW_mem_o,
    output logic        pc_sel_o,
    output logic [31:0] pc_target_o
);

    localparam logic [1:0] WB_PC4 = 2'b10;

    // EX/MEM register
    logic [31:0] alu_mem_q,    alu_mem_d;
    logic [31:0] rs2_mem_q,    rs2_mem_d;
    logic [31:0] pc4_mem_q,    pc4_mem_d;
    logic [31:0] inst_mem_q,   inst_mem_d;
    logic        MemRW_mem_q,  MemRW_mem_d;
    logic        RegWEn_mem_q, RegWEn_mem_d;
    logic [1:0]  WBSel_mem_q,  WBSel_mem_d;
    logic [4:0]  rsW_mem_q,    rsW_mem_d;

    logic [31:0] mem_fwd_val;
    logic [31:0] fwd_rs1, fwd_rs2;
    logic [31:0] op_a, op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [2:0]  funct3;
    logic        br_taken;
    logic        accept;

    // A jal/jalr sitting in MEM writes pc+4, everything else forwardable writes the ALU result.
    assign mem_fwd_val = (WBSel_mem_q == WB_PC4) ? pc4_mem_q : alu_mem_q;

    // MEM hit has priority over WB hit because it is the younger producer.
    always_comb begin
        fwd_rs1 = rs1_ex_i;
        if (FWD_EN && (rs1A_ex_i != 5'd0)) begin
            if (RegWEn_mem_q && (rsW_mem_q == rs1A_ex_i)) begin
                fwd_rs1 = mem_fwd_val;
            end else if (RegWEn_wb_i && (rsW_wb_i == rs1A_ex_i)) begin
                fwd_rs1 = wb_data_i;
            end
        end
    end

    always_comb begin
        fwd_rs2 = rs2_ex_i;
        if (FWD_EN && (rs2A_ex_i != 5'd0)) begin
            if (RegWEn_mem_q && (rsW_mem_q == rs2A_ex_i)) begin
                fwd_rs2 = mem_fwd_val;
            end else if (RegWEn_wb_i && (rsW_wb_i == rs2A_ex_i)) begin
                fwd_rs2 = wb_data_i;
            end
        end
    end

    assign op_a  = ASel_ex_i ? pc_ex_i  : fwd_rs1;
    assign op_b  = BSel_ex_i ? imm_ex_i : fwd_rs2;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = 32'd0;
        case (ALUSel_ex_i)
            4'd0:  alu_res = op_a + op_b;
            4'd1:  alu_res = op_a - op_b;
            4'd2:  alu_res = op_a << shamt;
            4'd3:  alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
            4'd4:  alu_res = {31'd0, (op_a < op_b)};
            4'd5:  alu_res = op_a ^ op_b;
            4'd6:  alu_res = op_a >> shamt;
            4'd7:  alu_res = $unsigned($signed(op_a) >>> shamt);
            4'd8:  alu_res = op_a | op_b;
            4'd9:  alu_res = op_a & op_b;
            4'd15: alu_res = op_b;
            default: alu_res = 32'd0;
        endcase
    end

    // Branch condition always compares the forwarded registers, independent of ASel/BSel.
    assign funct3 = inst_ex_i[14:12];

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (fwd_rs1 == fwd_rs2);
            3'b001:  br_taken = (fwd_rs1 != fwd_rs2);
            3'b100:  br_taken = ($signed(fwd_rs1) <  $signed(fwd_rs2));
            3'b101:  br_taken = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            3'b110:  br_taken = (fwd_rs1 <  fwd_rs2);
            3'b111:  br_taken = (fwd_rs1 >= fwd_rs2);
            default: br_taken = 1'b0;
        endcase
    end

    assign accept      = valid_ex_i && !flush_i;
    assign pc_sel_o    = accept && (Jump_ex_i || (BrEn_ex_i && br_taken));
    assign pc_target_o = {alu_res[31:1], 1'b0};

    always_comb begin
        alu_mem_d    = 32'd0;
        rs2_mem_d    = 32'd0;
        pc4_mem_d    = 32'd0;
        inst_mem_d   = NOP_INST;
        MemRW_mem_d  = 1'b0;
        RegWEn_mem_d = 1'b0;
        WBSel_mem_d  = 2'b00;
        rsW_mem_d    = 5'd0;
        if (accept) begin
            alu_mem_d    = alu_res;
            rs2_mem_d    = fwd_rs2;
            pc4_mem_d    = pc_ex_i + 32'd4;
            inst_mem_d   = inst_ex_i;
            MemRW_mem_d  = MemRW_ex_i;
            RegWEn_mem_d = RegWEn_ex_i;
            WBSel_mem_d  = WBSel_ex_i;
            rsW_mem_d    = rsW_ex_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_mem_q    <= 32'd0;
            rs2_mem_q    <= 32'd0;
            pc4_mem_q    <= 32'd0;
            inst_mem_q   <= NOP_INST;
            MemRW_mem_q  <= 1'b0;
            RegWEn_mem_q <= 1'b0;
            WBSel_mem_q  <= 2'b00;
            rsW_mem_q    <= 5'd0;
        end else begin
            alu_mem_q    <= alu_mem_d;
            rs2_mem_q    <= rs2_mem_d;
            pc4_mem_q    <= pc4_mem_d;
            inst_mem_q   <= inst_mem_d;
            MemRW_mem_q  <= MemRW_mem_d;
            RegWEn_mem_q <= RegWEn_mem_d;
            WBSel_mem_q  <= WBSel_mem_d;
            rsW_mem_q    <= rsW_mem_d;
        end
    end

    assign alu_mem_o    = alu_mem_q;
    assign rs2_mem_o    = rs2_mem_q;
    assign pc4_mem_o    = pc4_mem_q;
    assign inst_mem_o   = inst_mem_q;
    assign MemRW_mem_o  = MemRW_mem_q;
    assign RegWEn_mem_o = RegWEn_mem_q;
    assign WBSel_mem_o  = WBSel_mem_q;
    assign rsW_mem_o    = rsW_mem_q;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_ex_i;
    logic [31:0] pc_ex_i, rs1_ex_i, rs2_ex_i, imm_ex_i, inst_ex_i, wb_data_i;
    logic [4:0]  rs1A_ex_i, rs2A_ex_i, rsW_ex_i, rsW_wb_i;
    logic [3:0]  ALUSel_ex_i;
    logic        ASel_ex_i, BSel_ex_i, BrEn_ex_i, Jump_ex_i, MemRW_ex_i, RegWEn_ex_i;
    logic        flush_i, RegWEn_wb_i;
    logic [1:0]  WBSel_ex_i;
    logic [31:0] alu_mem_o, rs2_mem_o, pc4_mem_o, inst_mem_o, pc_target_o;
    logic        MemRW_mem_o, RegWEn_mem_o, pc_sel_o;
    logic [1:0]  WBSel_mem_o;
    logic [4:0]  rsW_mem_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1, rs2;
        logic [4:0]  rs1a, rs2a;
        logic [31:0] imm, inst;
        logic [3:0]  alusel;
        logic        asel, bsel, bren, jump, memrw;
        logic [1:0]  wbsel;
        logic        regw;
        logic [4:0]  rsw;
        logic        flush;
        logic [31:0] wbd;
        logic [4:0]  wbrd;
        logic        wben;
    } in_t;

    typedef struct packed {
        logic [31:0] alu, rs2, pc4, inst;
        logic        memrw, regw;
        logic [1:0]  wbsel;
        logic [4:0]  rsw;
    } mem_t;

    in_t  cur;
    mem_t m;   // model of what the memory stage should currently see

    ex_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_ex_i(valid_ex_i), .pc_ex_i(pc_ex_i),
        .rs1_ex_i(rs1_ex_i), .rs2_ex_i(rs2_ex_i), .rs1A_ex_i(rs1A_ex_i), .rs2A_ex_i(rs2A_ex_i),
        .imm_ex_i(imm_ex_i), .inst_ex_i(inst_ex_i), .ALUSel_ex_i(ALUSel_ex_i),
        .ASel_ex_i(ASel_ex_i), .BSel_ex_i(BSel_ex_i), .BrEn_ex_i(BrEn_ex_i), .Jump_ex_i(Jump_ex_i),
        .MemRW_ex_i(MemRW_ex_i), .WBSel_ex_i(WBSel_ex_i), .RegWEn_ex_i(RegWEn_ex_i),
        .rsW_ex_i(rsW_ex_i), .flush_i(flush_i), .wb_data_i(wb_data_i), .rsW_wb_i(rsW_wb_i),
        .RegWEn_wb_i(RegWEn_wb_i), .alu_mem_o(alu_mem_o), .rs2_mem_o(rs2_mem_o),
        .pc4_mem_o(pc4_mem_o), .inst_mem_o(inst_mem_o), .MemRW_mem_o(MemRW_mem_o),
        .RegWEn_mem_o(RegWEn_mem_o), .WBSel_mem_o(WBSel_mem_o), .rsW_mem_o(rsW_mem_o),
        .pc_sel_o(pc_sel_o), .pc_target_o(pc_target_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic mem_t reset_mem();
        mem_t r = '0;
        r.inst = NOP;
        return r;
    endfunction

    function automatic logic [31:0] fwd_ref(logic [4:0] idx, logic [31:0] rf, in_t x);
        if (idx == 5'd0) return rf;
        if (m.regw && m.rsw == idx) return (m.wbsel == 2'b10) ? m.pc4 : m.alu;
        if (x.wben && x.wbrd == idx) return x.wbd;
        return rf;
    endfunction

    function automatic longint as_signed(logic [31:0] v);
        longint u = longint'({32'd0, v});
        return v[31] ? (u - 64'sh1_0000_0000) : u;
    endfunction

    function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint sa = as_signed(a);
        longint sb = as_signed(b);
        longint p2 = longint'(1) << b[4:0];
        longint r;
        case (op)
            4'd0:  r = ua + ub;
            4'd1:  r = ua - ub;
            4'd2:  r = ua * p2;
            4'd3:  r = (sa < sb) ? 64'sd1 : 64'sd0;
            4'd4:  r = (ua < ub) ? 64'sd1 : 64'sd0;
            4'd5:  r = ua ^ ub;
            4'd6:  r = ua / p2;
            4'd7:  r = (sa >= 0) ? sa / p2 : -((-sa + p2 - 1) / p2);  // floor division
            4'd8:  r = ua | ub;
            4'd9:  r = ua & ub;
            4'd15: r = ub;
            default: r = 64'sd0;
        endcase
        return r[31:0];
    endfunction

    function automatic logic taken_ref(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return as_signed(a) <  as_signed(b);
            3'b101: return as_signed(a) >= as_signed(b);
            3'b110: return {32'd0, a} <  {32'd0, b};
            3'b111: return {32'd0, a} >= {32'd0, b};
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_alu(in_t x);
        logic [31:0] a = x.asel ? x.pc  : fwd_ref(x.rs1a, x.rs1, x);
        logic [31:0] b = x.bsel ? x.imm : fwd_ref(x.rs2a, x.rs2, x);
        return alu_ref(x.alusel, a, b);
    endfunction

    function automatic logic exp_sel(in_t x);
        logic t = taken_ref(x.inst[14:12], fwd_ref(x.rs1a, x.rs1, x), fwd_ref(x.rs2a, x.rs2, x));
        return x.valid && !x.flush && (x.jump || (x.bren && t));
    endfunction

    function automatic mem_t model_next(in_t x);
        mem_t r = reset_mem();
        if (x.valid && !x.flush) begin
            r.alu   = exp_alu(x);
            r.rs2   = fwd_ref(x.rs2a, x.rs2, x);
            r.pc4   = x.pc + 32'd4;
            r.inst  = x.inst;
            r.memrw = x.memrw;
            r.regw  = x.regw;
            r.wbsel = x.wbsel;
            r.rsw   = x.rsw;
        end
        return r;
    endfunction

    function automatic mem_t dut_mem();
        return {alu_mem_o, rs2_mem_o, pc4_mem_o, inst_mem_o,
                MemRW_mem_o, RegWEn_mem_o, WBSel_mem_o, rsW_mem_o};
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic in_t idle();
        in_t x = '0;
        x.inst = NOP;
        return x;
    endfunction

    function automatic in_t alu_op(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        in_t x = idle();
        x.valid = 1'b1; x.alusel = op;
        x.rs1 = a; x.rs1a = 5'd5; x.rs2 = b; x.rs2a = 5'd6;
        x.inst = 32'h0000_0033;
        return x;
    endfunction

    task automatic apply(input in_t x);
        @(negedge clk_i);
        cur = x;
        valid_ex_i = x.valid; pc_ex_i = x.pc; rs1_ex_i = x.rs1; rs2_ex_i = x.rs2;
        rs1A_ex_i = x.rs1a; rs2A_ex_i = x.rs2a; imm_ex_i = x.imm; inst_ex_i = x.inst;
        ALUSel_ex_i = x.alusel; ASel_ex_i = x.asel; BSel_ex_i = x.bsel; BrEn_ex_i = x.bren;
        Jump_ex_i = x.jump; MemRW_ex_i = x.memrw; WBSel_ex_i = x.wbsel; RegWEn_ex_i = x.regw;
        rsW_ex_i = x.rsw; flush_i = x.flush; wb_data_i = x.wbd; rsW_wb_i = x.wbrd;
        RegWEn_wb_i = x.wben;
        #1;
    endtask

    task automatic tick();
        mem_t nm = model_next(cur);
        @(posedge clk_i);
        #1;
        m = nm;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        in_t x;
        m = reset_mem();
        apply(idle());
        #3;
        checks++;
        if (dut_mem() !== reset_mem()) begin
            errors++; $display("FAIL reset_state got %h exp %h", dut_mem(), reset_mem());
        end
        checks++;
        if (pc_sel_o !== 1'b0) begin
            errors++; $display("FAIL reset_pc_sel got %b exp 0", pc_sel_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        x = alu_op(4'd0, 32'd5, 32'd7);
        apply(x);
        tick();
        checks++;
        if (alu_mem_o !== 32'd12) begin
            errors++; $display("FAIL reset_first_add got %h exp 0000000c", alu_mem_o);
        end
    endtask

    task automatic test_forwarding();
        in_t x, y, z, w, j, s;
        x = idle(); x.valid = 1; x.imm = 32'h10; x.bsel = 1; x.regw = 1; x.rsw = 5'd1; x.wbsel = 2'b01;
        apply(x); tick();
        y = idle(); y.valid = 1; y.rs1a = 5'd1; y.rs1 = 32'hDEAD; y.rsw = 5'd2; y.regw = 1;
        y.wbsel = 2'b01; y.wben = 1; y.wbrd = 5'd1; y.wbd = 32'h20;
        apply(y); tick();
        checks++;
        if (alu_mem_o !== 32'h10) begin
            errors++; $display("FAIL fwd_mem_over_wb got %h exp 00000010", alu_mem_o);
        end
        apply(idle()); tick();
        apply(y); tick();
        checks++;
        if (alu_mem_o !== 32'h20) begin
            errors++; $display("FAIL fwd_wb_after_bubble got %h exp 00000020", alu_mem_o);
        end
        z = idle(); z.valid = 1; z.imm = 32'h55; z.bsel = 1; z.regw = 1; z.rsw = 5'd0; z.wbsel = 2'b01;
        apply(z); tick();
        w = idle(); w.valid = 1; w.wben = 1; w.wbrd = 5'd0; w.wbd = 32'h77;
        apply(w); tick();
        checks++;
        if (alu_mem_o !== 32'h0) begin
            errors++; $display("FAIL fwd_x0_blocked got %h exp 00000000", alu_mem_o);
        end
        // jal x1 in MEM: a dependent store must receive pc+4, not the jump target.
        j = idle(); j.valid = 1; j.pc = 32'h300; j.jump = 1; j.asel = 1; j.bsel = 1; j.imm = 32'h8;
        j.regw = 1; j.rsw = 5'd1; j.wbsel = 2'b10;
        apply(j); tick();
        s = idle(); s.valid = 1; s.rs2a = 5'd1; s.rs2 = 32'hBAD; s.memrw = 1; s.imm = 32'h4; s.bsel = 1;
        apply(s); tick();
        checks++;
        if (rs2_mem_o !== 32'h304) begin
            errors++; $display("FAIL fwd_pc4_store got %h exp 00000304", rs2_mem_o);
        end
    endtask

    task automatic test_branch();
        in_t b;
        b = idle(); b.valid = 1; b.bren = 1; b.rs1a = 5'd7; b.rs1 = 32'h1;
        b.rs2a = 5'd8; b.rs2 = 32'hFFFF_FFFF; b.pc = 32'h100; b.imm = 32'h20; b.asel = 1; b.bsel = 1;
        b.inst = 32'h0000_4063;          // BLT: 1 < -1 is false
        apply(b);
        checks++;
        if (pc_sel_o !== 1'b0) begin
            errors++; $display("FAIL br_blt got %b exp 0", pc_sel_o);
        end
        b.inst = 32'h0000_6063;          // BLTU: 1 < 0xFFFFFFFF is true
        apply(b);
        checks++;
        if (pc_sel_o !== 1'b1) begin
            errors++; $display("FAIL br_bltu got %b exp 1", pc_sel_o);
        end
        checks++;
        if (pc_target_o !== 32'h120) begin
            errors++; $display("FAIL br_target got %h exp 00000120", pc_target_o);
        end
        b.inst = 32'h0000_2063;          // funct3 010: never taken
        apply(b);
        checks++;
        if (pc_sel_o !== 1'b0) begin
            errors++; $display("FAIL br_f3_010 got %b exp 0", pc_sel_o);
        end
        tick();
    endtask

    task automatic test_jalr();
        in_t j;
        j = idle(); j.valid = 1; j.jump = 1; j.rs1a = 5'd9; j.rs1 = 32'h203; j.bsel = 1; j.imm = 32'h0;
        j.pc = 32'h400; j.regw = 1; j.rsw = 5'd3; j.wbsel = 2'b10; j.inst = 32'h0004_81E7;
        apply(j);
        checks++;
        if (pc_target_o !== 32'h202) begin
            errors++; $display("FAIL jalr_target got %h exp 00000202", pc_target_o);
        end
        checks++;
        if (pc_sel_o !== 1'b1) begin
            errors++; $display("FAIL jalr_sel got %b exp 1", pc_sel_o);
        end
        tick();
        checks++;
        if (pc4_mem_o !== 32'h404 || WBSel_mem_o !== 2'b10) begin
            errors++; $display("FAIL jalr_mem got pc4=%h wbsel=%b exp pc4=00000404 wbsel=10",
                               pc4_mem_o, WBSel_mem_o);
        end
    endtask

    task automatic test_flush();
        in_t b;
        b = idle(); b.valid = 1; b.bren = 1; b.rs1a = 5'd10; b.rs1 = 32'h5; b.rs2a = 5'd11; b.rs2 = 32'h5;
        b.inst = 32'h0000_0063; b.regw = 1; b.memrw = 1; b.rsw = 5'd4; b.flush = 1;
        apply(b);
        checks++;
        if (pc_sel_o !== 1'b0) begin
            errors++; $display("FAIL flush_sel got %b exp 0", pc_sel_o);
        end
        tick();
        checks++;
        if (RegWEn_mem_o !== 1'b0 || MemRW_mem_o !== 1'b0 || inst_mem_o !== NOP) begin
            errors++; $display("FAIL flush_bubble got regw=%b memrw=%b inst=%h exp 0 0 %h",
                               RegWEn_mem_o, MemRW_mem_o, inst_mem_o, NOP);
        end
    endtask

    task automatic test_alu_edges();
        in_t x;
        x = alu_op(4'd7, 32'h8000_0000, 32'h0); x.bsel = 1; x.imm = 32'd31;
        apply(x); tick();
        checks++;
        if (alu_mem_o !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL alu_sra got %h exp ffffffff", alu_mem_o);
        end
        apply(alu_op(4'd1, 32'd0, 32'd1)); tick();
        checks++;
        if (alu_mem_o !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL alu_sub_wrap got %h exp ffffffff", alu_mem_o);
        end
        apply(alu_op(4'd0, 32'hFFFF_FFFF, 32'd1)); tick();
        checks++;
        if (alu_mem_o !== 32'd0) begin
            errors++; $display("FAIL alu_add_wrap got %h exp 00000000", alu_mem_o);
        end
        apply(alu_op(4'd12, 32'h1234, 32'h5678)); tick();
        checks++;
        if (alu_mem_o !== 32'd0) begin
            errors++; $display("FAIL alu_unused got %h exp 00000000", alu_mem_o);
        end
    endtask

    task automatic test_reset_mid();
        in_t x;
        x = alu_op(4'd5, 32'hF0F0_0000, 32'h0F0F_1234); x.regw = 1; x.rsw = 5'd2;
        apply(x); tick();
        apply(x);
        rst_ni = 1'b0;
        #1;
        m = reset_mem();
        checks++;
        if (dut_mem() !== reset_mem()) begin
            errors++; $display("FAIL reset_async got %h exp %h", dut_mem(), reset_mem());
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply(alu_op(4'd0, 32'd5, 32'd7)); tick();
        checks++;
        if (alu_mem_o !== 32'd12) begin
            errors++; $display("FAIL reset_release_add got %h exp 0000000c", alu_mem_o);
        end
    endtask

    task automatic test_back_to_back();
        in_t x;
        logic exp_s;
        logic [31:0] exp_t;
        for (int i = 0; i < 300; i++) begin
            x.valid  = ($urandom_range(7) != 0);
            x.flush  = ($urandom_range(7) == 0);
            x.pc     = {$urandom_range(32'hFFFF), 2'b00} & 32'h0003_FFFC;
            x.rs1    = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            x.rs2    = (i % 7 == 0) ? x.rs1 : $urandom;
            x.rs1a   = 5'($urandom_range(3));
            x.rs2a   = 5'($urandom_range(3));
            x.imm    = $urandom;
            x.inst   = $urandom;
            x.alusel = 4'($urandom_range(15));
            x.asel   = 1'($urandom_range(1));
            x.bsel   = 1'($urandom_range(1));
            x.bren   = 1'($urandom_range(1));
            x.jump   = ($urandom_range(5) == 0);
            x.memrw  = 1'($urandom_range(1));
            x.wbsel  = 2'($urandom_range(2));
            x.regw   = 1'($urandom_range(1));
            x.rsw    = 5'($urandom_range(3));
            x.wbd    = $urandom;
            x.wbrd   = 5'($urandom_range(3));
            x.wben   = 1'($urandom_range(1));
            apply(x);
            exp_s = exp_sel(x);
            exp_t = exp_alu(x) & 32'hFFFF_FFFE;
            checks++;
            if (pc_sel_o !== exp_s) begin
                errors++; $display("FAIL rand_pc_sel[%0d] got %b exp %b", i, pc_sel_o, exp_s);
            end
            checks++;
            if (pc_target_o !== exp_t) begin
                errors++; $display("FAIL rand_target[%0d] got %h exp %h", i, pc_target_o, exp_t);
            end
            tick();
            checks++;
            if (dut_mem() !== m) begin
                errors++; $display("FAIL rand_mem[%0d] got %h exp %h", i, dut_mem(), m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_branch();
        test_jalr();
        test_flush();
        test_alu_edges();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule
